// File: rtl/amp3_sample_fifo.sv
// Stereo sample FIFO feeding the Pmod AMP3 serializer.
// Stores (R,L) pairs and presents the head pair first-word-fall-through. A two-state
// prefill FSM holds out_valid low until START_LEVEL pairs are buffered. Underrun events
// (a take with nothing valid) are flagged and counted with saturation.
module amp3_sample_fifo #(
    parameter int unsigned dataW       = 12,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned START_LEVEL = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [dataW-1:0]           in_dataR,
    input  logic [dataW-1:0]           in_dataL,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [dataW-1:0]           out_dataR,
    output logic [dataW-1:0]           out_dataL,
    output logic                       out_valid,
    input  logic                       out_take,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       streaming,
    output logic                       underrun,
    output logic [7:0]                 underrun_cnt,
    input  logic                       clr_underrun
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    localparam logic [0:0] StFill   = 1'b0;
    localparam logic [0:0] StStream = 1'b1;

    logic [2*dataW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic [0:0]    state_q, state_d;
    logic          underrun_q, underrun_d;
    logic [7:0]    cnt_q, cnt_d;

    logic push, pop, under_ev;

    // Handshake and event decode; full/empty come from the level count only.
    always_comb begin
        in_ready  = (level_q != LW'(DEPTH));
        out_valid = (state_q == StStream) && (level_q != '0);
        push      = in_valid & in_ready;
        pop       = out_take & out_valid;
        under_ev  = out_take & ~out_valid;
    end

    // Head pair, forced to zero whenever it is not valid.
    always_comb begin
        out_dataR = '0;
        out_dataL = '0;
        if (out_valid) begin
            out_dataR = mem[rd_ptr_q][2*dataW-1:dataW];
            out_dataL = mem[rd_ptr_q][dataW-1:0];
        end
    end

    // Next level, FSM state and underrun bookkeeping.
    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end

        state_d = state_q;
        if (state_q == StFill) begin
            // Uses the registered level, so streaming starts one clk after the threshold.
            if (level_q >= LW'(START_LEVEL)) begin
                state_d = StStream;
            end
        end else if (under_ev) begin
            state_d = StFill;
        end

        underrun_d = underrun_q;
        cnt_d      = cnt_q;
        if (under_ev) begin
            // A clear coinciding with an event restarts the count at this event.
            underrun_d = 1'b1;
            if (clr_underrun) begin
                cnt_d = 8'd1;
            end else if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
        end else if (clr_underrun) begin
            underrun_d = 1'b0;
            cnt_d      = 8'd0;
        end
    end

    // Sample storage; right channel in the upper half. Contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {in_dataR, in_dataL};
        end
    end

    // Pointers, level, FSM and underrun state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            state_q    <= StFill;
            underrun_q <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q    <= level_d;
            state_q    <= state_d;
            underrun_q <= underrun_d;
            cnt_q      <= cnt_d;
        end
    end

    assign level        = level_q;
    assign streaming    = (state_q == StStream);
    assign underrun     = underrun_q;
    assign underrun_cnt = cnt_q;

endmodule

// File: tb/tb_amp3_sample_fifo.sv
// Self-checking bench for amp3_sample_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the buffer.
module tb_amp3_sample_fifo;

    localparam int DW    = 12;
    localparam int DEPTH = 16;
    localparam int START = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_dataR = '0, in_dataL = '0;
    logic          in_valid = 1'b0, out_take = 1'b0, clr_underrun = 1'b0;
    logic          in_ready, out_valid, streaming, underrun;
    logic [DW-1:0] out_dataR, out_dataL;
    logic [4:0]    level;
    logic [7:0]    underrun_cnt;

    amp3_sample_fifo #(.dataW(DW), .DEPTH(DEPTH), .START_LEVEL(START)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_dataR     (in_dataR),
        .in_dataL     (in_dataL),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_dataR    (out_dataR),
        .out_dataL    (out_dataL),
        .out_valid    (out_valid),
        .out_take     (out_take),
        .level        (level),
        .streaming    (streaming),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .clr_underrun (clr_underrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: queue of {R,L} pairs plus streaming/underrun status.
    logic [2*DW-1:0] q[$];
    bit              m_stream = 0;
    bit              m_under  = 0;
    int              m_cnt    = 0;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_stream = 0;
        m_under  = 0;
        m_cnt    = 0;
    endtask

    // One clock: drive inputs, compare all outputs to the model, clock, advance model.
    task automatic step(input bit v, input logic [DW-1:0] r, input logic [DW-1:0] l,
                        input bit take, input bit clr);
        bit exp_ready, exp_ov, push, pop, ev;
        int old_lvl;
        logic [2*DW-1:0] head;
        in_valid     = v;
        in_dataR     = r;
        in_dataL     = l;
        out_take     = take;
        clr_underrun = clr;
        #2;
        exp_ready = (q.size() != DEPTH);
        exp_ov    = m_stream && (q.size() != 0);
        head      = exp_ov ? q[0] : '0;
        check_eq("level",     level,        q.size());
        check_eq("in_ready",  in_ready,     exp_ready);
        check_eq("out_valid", out_valid,    exp_ov);
        check_eq("out_dataR", out_dataR,    head[2*DW-1:DW]);
        check_eq("out_dataL", out_dataL,    head[DW-1:0]);
        check_eq("streaming", streaming,    m_stream);
        check_eq("underrun",  underrun,     m_under);
        check_eq("udr_cnt",   underrun_cnt, m_cnt);
        @(posedge clk);
        push    = v && exp_ready;
        pop     = take && exp_ov;
        ev      = take && !exp_ov;
        old_lvl = q.size();
        if (pop)  void'(q.pop_front());
        if (push) q.push_back({r, l});
        if (!m_stream) m_stream = (old_lvl >= START);
        else if (ev)   m_stream = 0;
        if (ev) begin
            m_under = 1;
            m_cnt   = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        end else if (clr) begin
            m_under = 0;
            m_cnt   = 0;
        end
        #1;
        in_valid     = 1'b0;
        out_take     = 1'b0;
        clr_underrun = 1'b0;
    endtask

    task automatic push_rand();
        step(1'b1, DW'($urandom), DW'($urandom), 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        #2;
        check_eq("rst_level",   level,        0);
        check_eq("rst_ready",   in_ready,     1);
        check_eq("rst_ovalid",  out_valid,    0);
        check_eq("rst_dataR",   out_dataR,    0);
        check_eq("rst_udr",     underrun,     0);
        check_eq("rst_cnt",     underrun_cnt, 0);
        #20 rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // 1: prefill, output withheld until START_LEVEL pairs buffered
        for (int i = 0; i < 7; i++) step(1'b1, DW'(i), ~DW'(i), 1'b0, 1'b0);
        check_eq("t1_level7", level, 7);
        check_eq("t1_ov0",    out_valid, 0);
        step(1'b1, DW'(7), ~DW'(7), 1'b0, 1'b0);
        check_eq("t1_ov_lag", out_valid, 0);
        idle();
        check_eq("t1_ov1",    out_valid, 1);
        check_eq("t1_dataR",  out_dataR, 0);
        check_eq("t1_dataL",  out_dataL, 12'hFFF);
        check_eq("t1_stream", streaming, 1);

        // 2: fill to full, push+take when full, then drain across the wrap
        while (q.size() < DEPTH) step(1'b1, DW'(q.size() + 8), DW'($urandom), 1'b0, 1'b0);
        check_eq("t2_full", in_ready, 0);
        step(1'b1, 12'hABC, 12'h123, 1'b1, 1'b0);
        check_eq("t2_level15", level, 15);
        check_eq("t2_ready",   in_ready, 1);
        for (int i = 0; i < 15; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
        check_eq("t2_empty", level, 0);

        // 3: level 1 in STREAM, push and take together
        push_rand();
        step(1'b1, 12'h5A5, 12'hA5A, 1'b1, 1'b0);
        check_eq("t3_level1", level, 1);
        check_eq("t3_dataR",  out_dataR, 12'h5A5);
        check_eq("t3_dataL",  out_dataL, 12'hA5A);

        // 4: drain, three underrun takes, then clear together with a fourth
        step(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
        check_eq("t4_udr",    underrun, 1);
        check_eq("t4_cnt3",   underrun_cnt, 3);
        check_eq("t4_fill",   streaming, 0);
        step(1'b0, '0, '0, 1'b1, 1'b1);
        check_eq("t4_cnt1",   underrun_cnt, 1);
        check_eq("t4_udr1",   underrun, 1);

        // 5: counter saturation and clear
        for (int i = 0; i < 300; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
        check_eq("t5_sat", underrun_cnt, 255);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        check_eq("t5_clr_cnt", underrun_cnt, 0);
        check_eq("t5_clr_udr", underrun, 0);

        // Random traffic with varying producer/consumer rates
        for (int ph = 0; ph < 12; ph++) begin
            int pv = $urandom_range(10, 95);
            int pt = $urandom_range(5, 90);
            for (int i = 0; i < 150; i++) begin
                step(($urandom_range(0, 99) < pv), DW'($urandom), DW'($urandom),
                     ($urandom_range(0, 99) < pt), ($urandom_range(0, 99) < 3));
            end
        end

        // 6: asynchronous reset mid-stream with level 10
        for (int i = 0; i < 40 && q.size() != 0; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
        while (q.size() < 10) push_rand();
        idle();
        idle();
        check_eq("t6_pre_lvl", level, 10);
        check_eq("t6_pre_ov",  out_valid, 1);
        #3 rst = 1'b1;
        #1;
        check_eq("t6_ov",    out_valid, 0);
        check_eq("t6_level", level, 0);
        check_eq("t6_dataR", out_dataR, 0);
        check_eq("t6_dataL", out_dataL, 0);
        check_eq("t6_strm",  streaming, 0);
        #12 rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        for (int i = 0; i < 12; i++) push_rand();
        for (int i = 0; i < 14; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1);
    end

endmodule
